fft_r2_stage_ctrl: RTL and testbench



---
 rtl/fft_r2_stage_ctrl_if.sv | 29 ++
 rtl/fft_r2_stage_ctrl.sv | 99 +++++++++
 tb/tb_fft_r2_stage_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fft_r2_stage_ctrl_if.sv
// Control-side signal bundle of one radix-2 SDF FFT stage sequencer:
// the input strobe, FIFO flags and enables, and the butterfly/twiddle markers.
interface fft_r2_stage_ctrl_if #(
  parameter int TF_ADDR_LEN = 6
);
  logic                   data_in_valid;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_wr_en;
  logic                   fifo_rd_en;
  logic                   pair_valid;
  logic [TF_ADDR_LEN-1:0] tf_addr;
  logic                   frame_start;
  logic                   frame_done;
  logic                   busy;
  logic                   err;

  modport master (
    output data_in_valid, fifo_full, fifo_empty,
    input  fifo_wr_en, fifo_rd_en, pair_valid, tf_addr,
           frame_start, frame_done, busy, err
  );

  modport slave (
    input  data_in_valid, fifo_full, fifo_empty,
    output fifo_wr_en, fifo_rd_en, pair_valid, tf_addr,
           frame_start, frame_done, busy, err
  );
endinterface

// File: rtl/fft_r2_stage_ctrl.sv
// Sequencer for one radix-2 SDF FFT stage: fills the half-frame FIFO, then pairs
// each second-half sample with the stored first-half sample and issues twiddle addresses.
//
// state | meaning
// IDLE  | waiting for sample 0 of the first frame
// FILL  | writing first-half samples into the FIFO
// PAIR  | reading FIFO, one read per second-half sample
// ERR   | FIFO misuse seen; held until reset
module fft_r2_stage_ctrl #(
  parameter int HALF_LEN    = 64,
  parameter int CNT_LEN     = 6,
  parameter int TF_ADDR_LEN = 6,
  parameter int TF_STEP     = 1
) (
  input  logic             clk,
  input  logic             rst,
  fft_r2_stage_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FILL, PAIR, ERR} state_t;

  localparam logic [CNT_LEN-1:0] CNT_LAST = CNT_LEN'(HALF_LEN - 1);

  state_t                 state, state_nxt;
  logic [CNT_LEN-1:0]     cnt, cnt_nxt;
  logic                   wr_en, rd_en, last, fault;
  logic [TF_ADDR_LEN-1:0] tf_nxt, tf_addr;
  logic                   pair_valid, frame_start, frame_done, err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_en     = bus.data_in_valid & ((state == IDLE) | (state == FILL));
    rd_en     = bus.data_in_valid & (state == PAIR);
    last      = (cnt == CNT_LAST);
    // Full is legal only at the very start of PAIR, before the first read drains it
    fault     = (wr_en & bus.fifo_full) | (rd_en & bus.fifo_empty) |
                ((state == PAIR) & bus.fifo_full & (cnt != '0));
    tf_nxt    = TF_ADDR_LEN'(32'(cnt) * 32'(TF_STEP));
    if (fault) begin
      state_nxt = ERR;
    end else begin
      case (state)
        IDLE: begin
          if (bus.data_in_valid) begin
            cnt_nxt   = CNT_LEN'(1);
            state_nxt = FILL;
          end
        end
        FILL, PAIR: begin
          if (bus.data_in_valid) begin
            if (last) begin
              cnt_nxt   = '0;
              state_nxt = (state == FILL) ? PAIR : FILL;
            end else begin
              cnt_nxt = cnt + CNT_LEN'(1);
            end
          end
        end
        ERR:     ;
        default: state_nxt = ERR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pair_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      tf_addr     <= '0;
      err         <= 1'b0;
    end else begin
      pair_valid  <= rd_en & ~fault;
      frame_start <= rd_en & ~fault & (cnt == '0);
      frame_done  <= rd_en & ~fault & last;
      if (rd_en) tf_addr <= tf_nxt;
      if (fault) err <= 1'b1;
    end
  end

  assign bus.fifo_wr_en  = wr_en;
  assign bus.fifo_rd_en  = rd_en;
  assign bus.pair_valid  = pair_valid;
  assign bus.tf_addr     = tf_addr;
  assign bus.frame_start = frame_start;
  assign bus.frame_done  = frame_done;
  assign bus.busy        = (state == FILL) | (state == PAIR);
  assign bus.err         = err;
endmodule

// File: tb/tb_fft_r2_stage_ctrl.sv
// Bench for fft_r2_stage_ctrl: a frame-position reference model with a FIFO occupancy
// model feeds a pair scoreboard; TF_STEP=1 and TF_STEP=4 instances run side by side.
module tb_fft_r2_stage_ctrl;
  localparam int H = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_r2_stage_ctrl_if #(.TF_ADDR_LEN(6)) bus ();
  fft_r2_stage_ctrl_if #(.TF_ADDR_LEN(6)) bus4 ();

  assign bus4.data_in_valid = bus.data_in_valid;
  assign bus4.fifo_full     = bus.fifo_full;
  assign bus4.fifo_empty    = bus.fifo_empty;

  fft_r2_stage_ctrl #(.HALF_LEN(H), .CNT_LEN(6), .TF_ADDR_LEN(6), .TF_STEP(1)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
  fft_r2_stage_ctrl #(.HALF_LEN(H), .CNT_LEN(6), .TF_ADDR_LEN(6), .TF_STEP(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave));

  typedef struct {
    logic [5:0] tf1;
    logic [5:0] tf4;
    bit         start;
    bit         done;
  } sb_t;

  typedef struct {
    int n_cyc;
    int vld_cycles;
    bit toggle;
    int wr;
    int rd;
    int done;
    int first_pv;
    int last_done;
  } vec_t;

  int         n_checks = 0;
  int         n_errors = 0;
  int         pos, occ, cyc;
  bit         started, m_err, force_empty;
  logic [5:0] exp_tf1, exp_tf4;
  sb_t        sb_q[$];
  int         n_wr, n_rd, n_done, first_pv, last_done;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic clear_stats();
    cyc = 0; n_wr = 0; n_rd = 0; n_done = 0; first_pv = -1; last_done = -1;
  endtask

  task automatic do_reset(input bit v);
    @(negedge clk);
    rst = 1'b1;
    bus.data_in_valid = v;
    bus.fifo_full = 1'b0;
    bus.fifo_empty = 1'b1;
    @(posedge clk);
    #1;
    pos = 0; occ = 0; started = 0; m_err = 0; force_empty = 0;
    sb_q.delete();
    exp_tf1 = '0; exp_tf4 = '0;
    chk("rst_pair_valid", bus.pair_valid, 0);
    chk("rst_frame_start", bus.frame_start, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_tf_addr", bus.tf_addr, 0);
    chk("rst_tf_addr4", bus4.tf_addr, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_busy", bus.busy, 0);
  endtask

  task automatic step(input bit v);
    bit  ew, er, full, empty, fault;
    sb_t e;
    @(negedge clk);
    rst = 1'b0;
    full  = (occ == H);
    empty = (occ == 0) || force_empty;
    bus.fifo_full = full;
    bus.fifo_empty = empty;
    bus.data_in_valid = v;
    #2;
    ew = v && !m_err && (pos < H);
    er = v && !m_err && (pos >= H);
    chk("fifo_wr_en", bus.fifo_wr_en, int'(ew));
    chk("fifo_rd_en", bus.fifo_rd_en, int'(er));
    if (bus.fifo_wr_en) n_wr++;
    if (bus.fifo_rd_en) n_rd++;
    fault = (ew && full) || (er && empty) || (!m_err && pos > H && full);
    if (fault) begin
      m_err = 1;
    end else if (v && !m_err) begin
      if (er) begin
        e.tf1   = 6'(pos - H);
        e.tf4   = 6'((pos - H) * 4);
        e.start = (pos == H);
        e.done  = (pos == 2*H - 1);
        sb_q.push_back(e);
        occ--;
      end else begin
        occ++;
      end
      started = 1;
      pos = (pos + 1) % (2*H);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      exp_tf1 = e.tf1;
      exp_tf4 = e.tf4;
      chk("pair_valid", bus.pair_valid, 1);
      chk("frame_start", bus.frame_start, int'(e.start));
      chk("frame_done", bus.frame_done, int'(e.done));
    end else begin
      chk("pair_valid_idle", bus.pair_valid, 0);
      chk("frame_start_idle", bus.frame_start, 0);
      chk("frame_done_idle", bus.frame_done, 0);
    end
    chk("tf_addr", bus.tf_addr, exp_tf1);
    chk("tf_addr_step4", bus4.tf_addr, exp_tf4);
    chk("err", bus.err, int'(m_err));
    chk("busy", bus.busy, int'(started && !m_err));
    if (bus.pair_valid && first_pv < 0) first_pv = cyc;
    if (bus.frame_done) begin
      n_done++;
      last_done = cyc;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[3];
    vecs[0] = '{n_cyc: 129, vld_cycles: 128, toggle: 0, wr: 64,  rd: 64,  done: 1, first_pv: 65,  last_done: 128};
    vecs[1] = '{n_cyc: 257, vld_cycles: 256, toggle: 0, wr: 128, rd: 128, done: 2, first_pv: 65,  last_done: 256};
    vecs[2] = '{n_cyc: 257, vld_cycles: 256, toggle: 1, wr: 64,  rd: 64,  done: 1, first_pv: 129, last_done: 255};

    bus.data_in_valid = 1'b0;
    bus.fifo_full = 1'b0;
    bus.fifo_empty = 1'b1;
    force_empty = 0;

    for (int i = 0; i < 3; i++) begin
      do_reset(0);
      clear_stats();
      for (int c = 0; c < vecs[i].n_cyc; c++)
        step((c < vecs[i].vld_cycles) && (!vecs[i].toggle || (c % 2 == 0)));
      chk($sformatf("row%0d_writes", i), n_wr, vecs[i].wr);
      chk($sformatf("row%0d_reads", i), n_rd, vecs[i].rd);
      chk($sformatf("row%0d_done_pulses", i), n_done, vecs[i].done);
      chk($sformatf("row%0d_first_pair_cycle", i), first_pv, vecs[i].first_pv);
      chk($sformatf("row%0d_last_done_cycle", i), last_done, vecs[i].last_done);
    end

    // Empty FIFO at the first read of PAIR must trap into ERR until reset
    do_reset(0);
    clear_stats();
    for (int c = 0; c < H; c++) step(1);
    force_empty = 1;
    step(1);
    chk("err_trap_err", bus.err, 1);
    chk("err_trap_pair_valid", bus.pair_valid, 0);
    force_empty = 0;
    step(1);
    step(0);
    do_reset(0);
    step(1);
    chk("after_err_idle_write", n_wr, 65);

    // Reset in the middle of FILL, with a sample offered on the reset cycle
    do_reset(0);
    clear_stats();
    for (int c = 0; c < 30; c++) step(1);
    do_reset(1);
    clear_stats();
    for (int c = 0; c < 129; c++) step(c < 128);
    chk("post_rst_done_pulses", n_done, 1);
    chk("post_rst_first_pair_cycle", first_pv, 65);
    chk("post_rst_last_done_cycle", last_done, 128);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
